// File: rtl/cd_timer_pkg.sv
// Shared definitions for the countdown/stopwatch timer: FSM encoding,
// BCD digit limits and the width of the seconds-per-minute counter.
package cd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned HOUR_MAX  = 23;
  localparam int unsigned MIN_MAX   = 59;
  localparam int unsigned SEC_CNT_W = 7;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with a parameterised maximum value.
// Ports: clk, rst (async, active high); inc/dec/load controls (load > inc > dec);
//        load_tens/load_ones load value; tens/ones registered digits;
//        carry_c high when an inc wraps MAX->00, borrow_c when a dec wraps 00->MAX.
module bcd_mod_counter #(
  parameter int unsigned MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_c,
  output logic       borrow_c
);

  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MAX % 10);

  logic at_max;
  logic at_zero;

  assign at_max   = (tens == MAX_T) && (ones == MAX_O);
  assign at_zero  = (tens == 4'd0) && (ones == 4'd0);
  assign carry_c  = inc && !load && at_max;
  assign borrow_c = dec && !load && !inc && at_zero;

  // Digit register: units roll over at 9, whole value wraps at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (inc) begin
      if (at_max) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end else if (dec) begin
      if (at_zero) begin
        tens <= MAX_T;
        ones <= MAX_O;
      end else if (ones == 4'd0) begin
        tens <= tens - 4'd1;
        ones <= 4'd9;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/cd_timer_core.sv
// Countdown (HH:MM) / stopwatch (MM:SS) timer core with an editable preset.
// Ports: clk, rst (async, active high); set (edit preset), count_up_down
//        (1 = countdown, 0 = stopwatch), start_stop pulse, inc_h/inc_m pulses;
//        f_h1..f_m2 preset, h1/h2/m1_d/m2_d countdown, m1_up..s2_up stopwatch
//        (all BCD); done high while the countdown has expired.
module cd_timer_core
  import cd_timer_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 100_000_000,
  parameter int unsigned SEC_PER_MIN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       count_up_down,
  input  logic       start_stop,
  input  logic       inc_h,
  input  logic       inc_m,
  output logic [3:0] f_h1,
  output logic [3:0] f_h2,
  output logic [3:0] f_m1,
  output logic [3:0] f_m2,
  output logic [3:0] h1,
  output logic [3:0] h2,
  output logic [3:0] m1_d,
  output logic [3:0] m2_d,
  output logic [3:0] m1_up,
  output logic [3:0] m2_up,
  output logic [3:0] s1_up,
  output logic [3:0] s2_up,
  output logic       done
);

  localparam int unsigned PRESC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_TC = PRESC_W'(CLK_PER_SEC - 1);
  localparam logic [SEC_CNT_W-1:0] SEC_TC   = SEC_CNT_W'(SEC_PER_MIN - 1);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [SEC_CNT_W-1:0] sec_cnt_q;
  logic                 set_q;
  logic                 mode_q;

  logic sec_tick_c, mode_chg_c, set_ok_c, set_fall_c, run_en_c;
  logic min_tick_c, cd_zero_c, cd_one_c, expire_c;
  logic load_cd_c, clr_done_c, set_done_c;
  logic cd_m_borrow, sw_s_carry;

  logic pre_h_carry_unused, pre_h_borrow_unused;
  logic pre_m_carry_unused, pre_m_borrow_unused;
  logic cd_h_carry_unused, cd_h_borrow_unused, cd_m_carry_unused;
  logic sw_s_borrow_unused, sw_m_carry_unused, sw_m_borrow_unused;

  assign sec_tick_c = (state_q == ST_RUN) && (presc_q == PRESC_TC);
  assign mode_chg_c = (count_up_down != mode_q);
  // Preset editing is locked out while running.
  assign set_ok_c   = set && (state_q != ST_RUN);
  assign set_fall_c = set_q && !set && (state_q != ST_RUN);
  // A mode change pauses the run, so nothing advances in that cycle.
  assign run_en_c   = (state_q == ST_RUN) && !mode_chg_c;
  assign min_tick_c = run_en_c && count_up_down && sec_tick_c && (sec_cnt_q == SEC_TC);
  assign cd_zero_c  = ({h1, h2, m1_d, m2_d} == 16'h0000);
  assign cd_one_c   = ({h1, h2, m1_d, m2_d} == 16'h0001);
  // Expiry coincides with the decrement that lands on 00:00, or is immediate
  // when a run starts from 00:00.
  assign expire_c   = run_en_c && count_up_down && (cd_zero_c || (min_tick_c && cd_one_c));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control decode; set edge > mode change > expiry > start_stop
  always_comb begin
    state_d    = state_q;
    load_cd_c  = 1'b0;
    clr_done_c = 1'b0;
    set_done_c = 1'b0;
    if (set_fall_c) begin
      state_d    = ST_IDLE;
      load_cd_c  = 1'b1;
      clr_done_c = 1'b1;
    end else if (mode_chg_c) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (expire_c) begin
      state_d    = ST_DONE;
      set_done_c = 1'b1;
    end else if (start_stop && !set) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: state_d = ST_RUN;
        ST_RUN:            state_d = ST_PAUSE;
        ST_DONE: begin
          state_d    = ST_IDLE;
          load_cd_c  = 1'b1;
          clr_done_c = 1'b1;
        end
        default:           state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler, seconds-per-minute counter, edge trackers and done flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      sec_cnt_q <= '0;
      set_q     <= 1'b0;
      mode_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      set_q  <= set;
      mode_q <= count_up_down;

      if (state_q == ST_RUN)       presc_q <= sec_tick_c ? '0 : presc_q + PRESC_W'(1);
      else if (state_q == ST_IDLE) presc_q <= '0;

      if ((state_q == ST_IDLE) || load_cd_c)           sec_cnt_q <= '0;
      else if (run_en_c && count_up_down && sec_tick_c) sec_cnt_q <= min_tick_c ? '0 : sec_cnt_q + SEC_CNT_W'(1);

      if (set_done_c)      done <= 1'b1;
      else if (clr_done_c) done <= 1'b0;
    end
  end

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_pre_h (
    .clk(clk), .rst(rst), .inc(set_ok_c && inc_h), .dec(1'b0), .load(1'b0),
    .load_tens(4'd0), .load_ones(4'd0), .tens(f_h1), .ones(f_h2),
    .carry_c(pre_h_carry_unused), .borrow_c(pre_h_borrow_unused)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_pre_m (
    .clk(clk), .rst(rst), .inc(set_ok_c && inc_m), .dec(1'b0), .load(1'b0),
    .load_tens(4'd0), .load_ones(4'd0), .tens(f_m1), .ones(f_m2),
    .carry_c(pre_m_carry_unused), .borrow_c(pre_m_borrow_unused)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_cd_m (
    .clk(clk), .rst(rst), .inc(1'b0), .dec(min_tick_c && !cd_zero_c), .load(load_cd_c),
    .load_tens(f_m1), .load_ones(f_m2), .tens(m1_d), .ones(m2_d),
    .carry_c(cd_m_carry_unused), .borrow_c(cd_m_borrow)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_cd_h (
    .clk(clk), .rst(rst), .inc(1'b0), .dec(cd_m_borrow), .load(load_cd_c),
    .load_tens(f_h1), .load_ones(f_h2), .tens(h1), .ones(h2),
    .carry_c(cd_h_carry_unused), .borrow_c(cd_h_borrow_unused)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_sw_s (
    .clk(clk), .rst(rst), .inc(run_en_c && !count_up_down && sec_tick_c), .dec(1'b0),
    .load(1'b0), .load_tens(4'd0), .load_ones(4'd0), .tens(s1_up), .ones(s2_up),
    .carry_c(sw_s_carry), .borrow_c(sw_s_borrow_unused)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_sw_m (
    .clk(clk), .rst(rst), .inc(sw_s_carry), .dec(1'b0), .load(1'b0),
    .load_tens(4'd0), .load_ones(4'd0), .tens(m1_up), .ones(m2_up),
    .carry_c(sw_m_carry_unused), .borrow_c(sw_m_borrow_unused)
  );

endmodule

// File: tb/tb_cd_timer_core.sv
// Directed bench for cd_timer_core with CLK_PER_SEC=4, SEC_PER_MIN=2.
module tb_cd_timer_core;
  import cd_timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic set = 1'b0;
  logic count_up_down = 1'b1;
  logic start_stop = 1'b0;
  logic inc_h = 1'b0;
  logic inc_m = 1'b0;
  logic [3:0] f_h1, f_h2, f_m1, f_m2, h1, h2, m1_d, m2_d;
  logic [3:0] m1_up, m2_up, s1_up, s2_up;
  logic done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cd_timer_core #(.CLK_PER_SEC(4), .SEC_PER_MIN(2)) dut (
    .clk(clk), .rst(rst), .set(set), .count_up_down(count_up_down),
    .start_stop(start_stop), .inc_h(inc_h), .inc_m(inc_m),
    .f_h1(f_h1), .f_h2(f_h2), .f_m1(f_m1), .f_m2(f_m2),
    .h1(h1), .h2(h2), .m1_d(m1_d), .m2_d(m2_d),
    .m1_up(m1_up), .m2_up(m2_up), .s1_up(s1_up), .s2_up(s2_up),
    .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] preset_v();
    return {16'h0, f_h1, f_h2, f_m1, f_m2};
  endfunction

  function automatic logic [31:0] cd_v();
    return {16'h0, h1, h2, m1_d, m2_d};
  endfunction

  function automatic logic [31:0] sw_v();
    return {16'h0, m1_up, m2_up, s1_up, s2_up};
  endfunction

  function automatic logic [31:0] st_v();
    return 32'(dut.state_q);
  endfunction

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_in(input bit ss, input bit h, input bit m);
    start_stop = ss;
    inc_h = h;
    inc_m = m;
    cyc(1);
    start_stop = 1'b0;
    inc_h = 1'b0;
    inc_m = 1'b0;
  endtask

  task automatic incs(input bit h, input bit m, input int n);
    repeat (n) begin
      pulse_in(1'b0, h, m);
      cyc(1);
    end
  endtask

  initial begin
    cyc(3);
    check_eq("rst_preset", preset_v(), 32'h0000);
    check_eq("rst_cd", cd_v(), 32'h0000);
    check_eq("rst_sw", sw_v(), 32'h0000);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_state", st_v(), 32'(ST_IDLE));
    rst = 1'b0;
    cyc(2);

    // Preset editing with wraps
    set = 1'b1;
    cyc(1);
    incs(1'b1, 1'b0, 23);
    check_eq("pre_h_23", preset_v(), 32'h2300);
    incs(1'b1, 1'b0, 2);
    incs(1'b0, 1'b1, 59);
    check_eq("pre_m_59", preset_v(), 32'h0159);
    incs(1'b0, 1'b1, 2);
    check_eq("pre_0101", preset_v(), 32'h0101);
    check_eq("cd_not_loaded", cd_v(), 32'h0000);
    set = 1'b0;
    cyc(2);
    check_eq("pre_after_set", preset_v(), 32'h0101);
    check_eq("cd_load_0101", cd_v(), 32'h0101);

    // Simultaneous increments, then preset 00:01
    set = 1'b1;
    cyc(1);
    incs(1'b1, 1'b1, 1);
    check_eq("pre_both_0202", preset_v(), 32'h0202);
    incs(1'b1, 1'b0, 22);
    incs(1'b0, 1'b1, 59);
    set = 1'b0;
    cyc(2);
    check_eq("cd_load_0001", cd_v(), 32'h0001);

    // Countdown 00:01 expires 8 cycles after RUN entry
    pulse_in(1'b1, 1'b0, 1'b0);
    check_eq("run_entry", st_v(), 32'(ST_RUN));
    cyc(7);
    check_eq("cd_e7", cd_v(), 32'h0001);
    check_eq("done_e7", 32'(done), 32'd0);
    cyc(1);
    check_eq("cd_e8", cd_v(), 32'h0000);
    check_eq("done_e8", 32'(done), 32'd1);
    check_eq("state_done", st_v(), 32'(ST_DONE));
    cyc(5);
    check_eq("done_hold", 32'(done), 32'd1);
    check_eq("cd_hold_zero", cd_v(), 32'h0000);
    pulse_in(1'b1, 1'b0, 1'b0);
    check_eq("done_to_idle", st_v(), 32'(ST_IDLE));
    check_eq("done_clr", 32'(done), 32'd0);
    check_eq("cd_reload", cd_v(), 32'h0001);

    // Preset 01:00, one minute -> 00:59 with borrow
    set = 1'b1;
    cyc(1);
    incs(1'b1, 1'b0, 1);
    incs(1'b0, 1'b1, 59);
    check_eq("pre_0100", preset_v(), 32'h0100);
    set = 1'b0;
    cyc(2);
    check_eq("cd_load_0100", cd_v(), 32'h0100);
    pulse_in(1'b1, 1'b0, 1'b0);
    cyc(8);
    check_eq("cd_borrow_0059", cd_v(), 32'h0059);
    check_eq("cd_still_run", st_v(), 32'(ST_RUN));
    check_eq("sw_idle_cd", sw_v(), 32'h0000);
    pulse_in(1'b1, 1'b0, 1'b0);
    check_eq("paused", st_v(), 32'(ST_PAUSE));
    cyc(20);
    check_eq("pause_hold", cd_v(), 32'h0059);

    // Set edge from PAUSE reloads; set blocks start_stop in IDLE
    set = 1'b1;
    cyc(1);
    set = 1'b0;
    cyc(2);
    check_eq("pause_set_idle", st_v(), 32'(ST_IDLE));
    check_eq("pause_set_reload", cd_v(), 32'h0100);
    set = 1'b1;
    pulse_in(1'b1, 1'b0, 1'b1);
    check_eq("set_blocks_ss", st_v(), 32'(ST_IDLE));
    check_eq("set_edit_ok", preset_v(), 32'h0101);
    cyc(3);
    check_eq("set_still_idle", st_v(), 32'(ST_IDLE));
    set = 1'b0;
    cyc(2);
    check_eq("cd_load_0101b", cd_v(), 32'h0101);

    // Stopwatch up to 59:59 and wrap
    count_up_down = 1'b0;
    cyc(2);
    check_eq("mode_idle", st_v(), 32'(ST_IDLE));
    pulse_in(1'b1, 1'b0, 1'b0);
    cyc(4 * 3599 - 1);
    check_eq("sw_5958", sw_v(), 32'h5958);
    cyc(1);
    check_eq("sw_5959", sw_v(), 32'h5959);
    check_eq("cd_frozen", cd_v(), 32'h0101);
    cyc(4);
    check_eq("sw_wrap", sw_v(), 32'h0000);
    check_eq("sw_wrap_done", 32'(done), 32'd0);
    cyc(12);
    check_eq("sw_0003", sw_v(), 32'h0003);
    check_eq("sw_run", st_v(), 32'(ST_RUN));

    // Reset mid-run
    cyc(2);
    rst = 1'b1;
    #2;
    check_eq("mid_rst_sw", sw_v(), 32'h0000);
    check_eq("mid_rst_cd", cd_v(), 32'h0000);
    check_eq("mid_rst_pre", preset_v(), 32'h0000);
    check_eq("mid_rst_state", st_v(), 32'(ST_IDLE));
    cyc(1);
    rst = 1'b0;
    cyc(4);
    check_eq("post_rst_sw", sw_v(), 32'h0000);
    check_eq("post_rst_state", st_v(), 32'(ST_IDLE));
    cyc(4);
    check_eq("post_rst_sw2", sw_v(), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
